// File: rtl/uart_echo_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_responder
// Purpose  : Echoes bytes received from a UART receiver back out through a
//            UART transmitter. Received bytes are buffered in a circular
//            FIFO; a byte flagged with a framing error is replaced by
//            NAK_BYTE. A four-state TX machine launches one byte at a time
//            and waits for the transmitter to finish before the next launch.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   FIFO_DEPTH     : echo-buffer entries, power of 2 in 2..64
//   NAK_BYTE       : byte queued in place of a framing-error character
// Ports
//   clk            : in  1  rising-edge clock
//   rst            : in  1  asynchronous active-low reset; deassertion is
//                           expected to be synchronous to clk
//   enable         : in  1  accept received bytes into the FIFO when 1
//   rx_data        : in  8  byte from the UART receiver
//   rx_ready       : in  1  one-cycle pulse, rx_data valid
//   rx_error       : in  1  one-cycle pulse, framing error on current byte
//   tx_busy        : in  1  transmitter busy level
//   tx_done        : in  1  transmitter one-cycle completion pulse
//   tx_data        : out 8  byte presented to the transmitter
//   tx_start       : out 1  one-cycle launch pulse
//   fifo_count     : out $clog2(FIFO_DEPTH)+1  FIFO occupancy
//   overflow       : out 1  sticky, set when a byte is dropped
//   clear_overflow : in  1  synchronous clear of overflow
// ============================================================================
module uart_echo_responder #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [7:0]  NAK_BYTE   = 8'h15
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic [7:0]                    rx_data,
   input  logic                          rx_ready,
   input  logic                          rx_error,
   input  logic                          tx_busy,
   input  logic                          tx_done,
   output logic [7:0]                    tx_data,
   output logic                          tx_start,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   input  logic                          clear_overflow
);

   localparam int c_ptr_w = $clog2(FIFO_DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LAUNCH    = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_next;

   logic [7:0]           r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [c_cnt_w-1:0]   r_count;
   logic                 r_overflow;
   logic [7:0]           r_tx_data;
   logic                 r_tx_start;

   logic                 w_push;
   logic [7:0]           w_push_byte;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_accept;
   logic                 w_drop;

   // ------------------------------------------------------------------------
   // Push side
   // ------------------------------------------------------------------------
   assign w_push      = enable & (rx_ready | rx_error);
   assign w_push_byte = rx_error ? NAK_BYTE : rx_data;
   assign w_full      = (r_count == c_cnt_w'(FIFO_DEPTH));

   // A pop in the same cycle frees the slot being written, so a full FIFO
   // still accepts the push when a launch happens on that edge.
   assign w_accept    = w_push & (~w_full | w_pop);
   assign w_drop      = w_push & w_full & ~w_pop;

   // ------------------------------------------------------------------------
   // TX state machine: next state and pop decision
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Pop happens on the edge that enters LAUNCH; the head is
            // captured into tx_data on that same edge.
            if ((r_count != '0) && !tx_busy) begin
               w_state_next = S_LAUNCH;
               w_pop        = 1'b1;
            end
         end
         S_LAUNCH: begin
            w_state_next = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            // A completion without any observed busy period (very fast
            // transmitter) returns straight to IDLE; completion wins if both
            // arrive together so the machine cannot wait for a second done.
            if (tx_done) begin
               w_state_next = S_IDLE;
            end else if (tx_busy) begin
               w_state_next = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (tx_done) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Control registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_tx_data  <= 8'h00;
         r_tx_start <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_tx_start <= w_pop;

         if (w_pop) begin
            r_tx_data <= r_mem[r_rd_ptr];
            r_rd_ptr  <= r_rd_ptr + c_ptr_w'(1);
         end

         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end

         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase

         // A drop in the same cycle as a clear leaves the flag set.
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clear_overflow) begin
            r_overflow <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Storage: contents need no reset, validity is tracked by the pointers.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[r_wr_ptr] <= w_push_byte;
      end
   end

   assign tx_data    = r_tx_data;
   assign tx_start   = r_tx_start;
   assign fifo_count = r_count;
   assign overflow   = r_overflow;

endmodule
`default_nettype wire
